// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/DIV/REM unit that sits beside the single-cycle ALU.
// It accepts one request per valid/ready handshake and holds the result until the consumer takes it.
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Overflow,
    output logic             DivByZero,
    output logic             Illegal,
    output logic             Busy
);

    localparam logic [OP_W-1:0] OP_DIV = OP_W'(6'b001011);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_REM = OP_W'(6'b001101);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;
    logic               ill_q, ill_d;

    // Datapath working registers; only meaningful while a run is in flight.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplr_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               op_rem_q;

    logic               is_mul, is_div, is_rem, is_divrem, b_zero;
    logic               accept, last_iter;

    logic [WIDTH:0]     mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplr_nxt;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    assign is_mul    = (op == OP_MUL);
    assign is_div    = (op == OP_DIV);
    assign is_rem    = (op == OP_REM);
    assign is_divrem = is_div | is_rem;
    assign b_zero    = (B == '0);
    assign accept    = start_valid && (state_q == S_IDLE);
    assign last_iter = (cnt_q == LAST_CNT);

    // One shift-add step: add the multiplicand into the high half, then shift the
    // whole W+1-bit sum and low half right so the carry is never lost.
    assign mul_addend = mplr_q[0] ? {1'b0, mcand_q} : '0;
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_addend;
    assign acc_nxt    = {mul_sum, acc_q[WIDTH-1:1]};
    assign mplr_nxt   = mplr_q >> 1;

    // One restoring-division step; the shifted remainder needs W+1 bits to compare.
    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, divisor_q};
    assign div_ge   = (rem_sh >= {1'b0, divisor_q});
    assign rem_nxt  = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nxt  = {quo_q[WIDTH-2:0], div_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    if (is_mul) begin
                        state_d = S_MUL_RUN;
                    end else if (is_divrem) begin
                        state_d = b_zero ? S_DONE : S_DIV_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL_RUN: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DIV_RUN: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state_q == S_IDLE);
        result_valid = (state_q == S_DONE);
        Busy         = (state_q == S_MUL_RUN) || (state_q == S_DIV_RUN);
    end

    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign DivByZero = dbz_q;
    assign Illegal   = ill_q;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (Busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        result_d = result_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
        if (accept) begin
            ovf_d = 1'b0;
            dbz_d = 1'b0;
            ill_d = 1'b0;
            if (is_divrem && b_zero) begin
                result_d = is_div ? '1 : A;
                dbz_d    = 1'b1;
            end else if (!is_mul && !is_divrem) begin
                result_d = '0;
                ill_d    = 1'b1;
            end
        end else if ((state_q == S_MUL_RUN) && last_iter) begin
            result_d = acc_nxt[WIDTH-1:0];
            ovf_d    = |acc_nxt[2*WIDTH-1:WIDTH];
        end else if ((state_q == S_DIV_RUN) && last_iter) begin
            result_d = op_rem_q ? rem_nxt : quo_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

    // Operands are captured only at acceptance, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q     <= '0;
            mcand_q   <= A;
            mplr_q    <= B;
            divisor_q <= B;
            rem_q     <= '0;
            quo_q     <= A;
            op_rem_q  <= is_rem;
        end else if (state_q == S_MUL_RUN) begin
            acc_q  <= acc_nxt;
            mplr_q <= mplr_nxt;
        end else if (state_q == S_DIV_RUN) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: a driver pushes model results, a monitor pops
// them when the unit raises result_valid and compares value, flags and latency.
module tb_alu_muldiv_seq;

    localparam int W = 32;
    localparam logic [5:0] OP_DIV = 6'b001011;
    localparam logic [5:0] OP_MUL = 6'b001100;
    localparam logic [5:0] OP_REM = 6'b001101;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [5:0]    op = '0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [W-1:0]  Result;
    logic          Overflow, DivByZero, Illegal, Busy;

    alu_muldiv_seq #(.WIDTH(W), .OP_W(6)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .A(A), .B(B),
        .result_valid(result_valid), .result_ready(result_ready),
        .Result(Result), .Overflow(Overflow), .DivByZero(DivByZero),
        .Illegal(Illegal), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         dbz;
        logic         ill;
        int           lat;
        int           acc_cyc;
        logic [5:0]   op;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   hold_ready = 1'b0;
    bit   prev_v = 1'b0;
    exp_t cur;

    // Reference: plain unsigned arithmetic on the operation's definition.
    function automatic exp_t model(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        e.res = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.ill = 1'b0;
        e.lat = W; e.acc_cyc = 0; e.op = o;
        if (o == OP_MUL) begin
            p = (2*W)'(a) * (2*W)'(b);
            e.res = p[W-1:0];
            e.ovf = (p[2*W-1:W] != '0);
        end else if (o == OP_DIV || o == OP_REM) begin
            if (b == '0) begin
                e.dbz = 1'b1;
                e.lat = 0;
                e.res = (o == OP_DIV) ? '1 : a;
            end else begin
                e.res = (o == OP_DIV) ? (a / b) : (a % b);
            end
        end else begin
            e.ill = 1'b1;
            e.lat = 0;
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            result_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks each result on the cycle result_valid first rises, then its stability.
    initial begin
        cur = model(OP_MUL, '0, '0);
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (result_valid && !prev_v) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_result Result=%h with nothing outstanding", Result);
                        n_err++;
                        cur.res = Result;
                    end else begin
                        cur = sb.pop_front();
                        if (Result !== cur.res || Overflow !== cur.ovf || DivByZero !== cur.dbz ||
                            Illegal !== cur.ill || Busy !== 1'b0 || (cyc - cur.acc_cyc) != cur.lat) begin
                            $display("FAIL result op=%b got res=%h ovf=%b dbz=%b ill=%b busy=%b lat=%0d want res=%h ovf=%b dbz=%b ill=%b busy=0 lat=%0d",
                                     cur.op, Result, Overflow, DivByZero, Illegal, Busy, cyc - cur.acc_cyc,
                                     cur.res, cur.ovf, cur.dbz, cur.ill, cur.lat);
                            n_err++;
                        end
                    end
                end else if (result_valid && Result !== cur.res) begin
                    $display("FAIL result_hold got=%h want=%h", Result, cur.res);
                    n_err++;
                end
                prev_v = result_valid;
            end
        end
    end

    task automatic issue(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   g;
        g = 0;
        @(negedge clk);
        while (!start_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!start_ready) begin
            $display("FAIL start_ready_timeout got=0 want=1");
            n_err++;
            return;
        end
        op = o; A = a; B = b; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op = 6'($urandom); A = $urandom; B = $urandom;
        e = model(o, a, b);
        e.acc_cyc = cyc;
        sb.push_back(e);
        n_vec++;
        if (Busy !== (e.lat != 0)) begin
            $display("FAIL busy_after_accept op=%b got=%b want=%b", o, Busy, (e.lat != 0));
            n_err++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || !start_ready) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0 || !start_ready) begin
            $display("FAIL drain_timeout outstanding=%0d want=0", sb.size());
            n_err++;
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] rop;
        int g;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (Result !== '0 || Overflow !== 1'b0 || DivByZero !== 1'b0 || Illegal !== 1'b0 ||
            result_valid !== 1'b0 || Busy !== 1'b0 || start_ready !== 1'b1) begin
            $display("FAIL reset_state got res=%h ovf=%b dbz=%b ill=%b rv=%b busy=%b sr=%b want 0/0/0/0/0/0/1",
                     Result, Overflow, DivByZero, Illegal, result_valid, Busy, start_ready);
            n_err++;
        end
        @(negedge clk) rst = 1'b0;

        issue(OP_MUL, 32'd7, 32'd6);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        issue(OP_DIV, 32'd100, 32'd7);
        issue(OP_REM, 32'd100, 32'd7);
        issue(OP_DIV, 32'd5, 32'd0);
        issue(OP_REM, 32'd5, 32'd0);
        issue(6'b000000, 32'd3, 32'd4);
        issue(6'b111111, 32'd3, 32'd4);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'hFFFF_FFFF, 32'd1);
        drain();

        // Hold the result: it must stay put and new requests must not be taken.
        hold_ready = 1'b1;
        issue(OP_MUL, 32'd7, 32'd6);
        g = 0;
        while (!result_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (Result !== 32'd42 || start_ready !== 1'b0 || result_valid !== 1'b1) begin
                $display("FAIL hold_cycle%0d got res=%0d sr=%b rv=%b want res=42 sr=0 rv=1",
                         i, Result, start_ready, result_valid);
                n_err++;
            end
            start_valid = ~start_valid;
            op = OP_DIV; A = 32'd1; B = 32'd1;
        end
        start_valid = 1'b0;
        hold_ready = 1'b0;
        drain();

        // Reset in the middle of a multiply discards it.
        issue(OP_MUL, $urandom, $urandom);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (Result !== '0 || Overflow !== 1'b0 || DivByZero !== 1'b0 || Illegal !== 1'b0 ||
            result_valid !== 1'b0 || Busy !== 1'b0 || start_ready !== 1'b1) begin
            $display("FAIL midrun_reset got res=%h ovf=%b dbz=%b ill=%b rv=%b busy=%b sr=%b want 0/0/0/0/0/0/1",
                     Result, Overflow, DivByZero, Illegal, result_valid, Busy, start_ready);
            n_err++;
        end
        sb.delete();
        @(negedge clk) rst = 1'b0;
        issue(OP_DIV, 32'd9, 32'd3);
        drain();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       rop = OP_MUL;
                1:       rop = OP_DIV;
                2:       rop = OP_REM;
                default: rop = 6'($urandom);
            endcase
            issue(rop, pick_operand(), pick_operand());
        end
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
